// File: rtl/mem_port_pkg.sv
// Shared types and sizes for the per-CPU SRAM arbiter request ports.
package mem_port_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned N_PORTS    = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GAP,
    RESP
  } port_state_e;

  // One counter serves both the gap and the timeout, so size it for the larger.
  function automatic int unsigned cnt_width(input int unsigned gap, input int unsigned tmo);
    return $clog2(((gap > tmo) ? gap : tmo) + 1);
  endfunction

endpackage

// File: rtl/mem_req_port_if.sv
// CPU-side and arbiter-side signals of one request port; slave = the port, master = CPU/arbiter.
interface mem_req_port_if #(
  parameter int unsigned ADDR_W = mem_port_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W = mem_port_pkg::MEM_DATA_W
) ();

  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rsp_valid;
  logic              cpu_rsp_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rsp_err;
  logic              arb_rd_req;
  logic              arb_wr_req;
  logic [ADDR_W-1:0] arb_addr;
  logic [DATA_W-1:0] arb_wdata;
  logic              arb_done;
  logic [DATA_W-1:0] arb_rdata;

  modport slave (
    input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, cpu_rsp_ready, arb_done, arb_rdata,
    output cpu_req_ready, cpu_rsp_valid, cpu_rdata, cpu_rsp_err,
           arb_rd_req, arb_wr_req, arb_addr, arb_wdata
  );

  modport master (
    output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata, cpu_rsp_ready, arb_done, arb_rdata,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rdata, cpu_rsp_err,
           arb_rd_req, arb_wr_req, arb_addr, arb_wdata
  );

endinterface

// File: rtl/mem_port_cnt.sv
// Loadable down-counter that saturates at zero; used for the inter-request gap and the timeout.
module mem_port_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] val_o,
  output logic         zero_o
);

  logic [W-1:0] val_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
    end else if (load_i) begin
      val_q <= load_val_i;
    end else if (val_q != '0) begin
      val_q <= val_q - W'(1);
    end
  end

  assign val_o  = val_q;
  assign zero_o = (val_q == '0);

endmodule

// File: rtl/mem_req_port.sv
// CPU request adapter for one arbiter slot: turns valid/ready transactions into edge-detected request levels.
// Optional abort of stalled requests: define MEM_REQ_PORT_TIMEOUT_EN.
module mem_req_port
  import mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W         = MEM_ADDR_W,
  parameter int unsigned DATA_W         = MEM_DATA_W,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           reset,
  mem_req_port_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);

  port_state_e       state_q;
  logic              req_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_req_q;
  logic              wr_req_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_valid_q;
  logic              err_q;

  logic              accept_c;
  logic              done_c;
  logic              expire_c;
  logic              cnt_last_c;
  logic              cnt_load_c;
  logic [CNT_W-1:0]  cnt_load_val_c;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;

  mem_port_cnt #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_load_val_c),
    .val_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  assign accept_c   = (state_q == IDLE) && req_ready_q && bus.cpu_req_valid;
  assign done_c     = (state_q == WAIT) && bus.arb_done;
  // Loaded with N on entry, so the value reads 1 in the N-th cycle of the state.
  assign cnt_last_c = cnt_zero || (cnt_val == CNT_W'(1));

`ifdef MEM_REQ_PORT_TIMEOUT_EN
  assign expire_c = (state_q == WAIT) && !bus.arb_done && cnt_last_c;
`else
  assign expire_c = 1'b0;
`endif

  // Counter loads on entry to WAIT (timeout) and GAP.
  always_comb begin
    cnt_load_c     = 1'b0;
    cnt_load_val_c = '0;
`ifdef MEM_REQ_PORT_TIMEOUT_EN
    if (accept_c) begin
      cnt_load_c     = 1'b1;
      cnt_load_val_c = CNT_W'(TIMEOUT_CYCLES);
    end
`endif
    if (done_c || expire_c) begin
      cnt_load_c     = 1'b1;
      cnt_load_val_c = CNT_W'(GAP_CYCLES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            req_ready_q <= 1'b0;
            we_q        <= bus.cpu_we;
            addr_q      <= bus.cpu_addr;
            wdata_q     <= bus.cpu_wdata;
            rd_req_q    <= ~bus.cpu_we;
            wr_req_q    <= bus.cpu_we;
            state_q     <= WAIT;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        WAIT: begin
          // Completion takes priority over a timeout in the same cycle.
          if (done_c) begin
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            rdata_q  <= we_q ? '0 : bus.arb_rdata;
            err_q    <= 1'b0;
            state_q  <= GAP;
          end else if (expire_c) begin
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b1;
            state_q  <= GAP;
          end
        end
        GAP: begin
          if (cnt_last_c) begin
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.cpu_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_req_ready = req_ready_q;
  assign bus.cpu_rsp_valid = rsp_valid_q;
  assign bus.cpu_rdata     = rdata_q;
  assign bus.cpu_rsp_err   = err_q;
  assign bus.arb_rd_req    = rd_req_q;
  assign bus.arb_wr_req    = wr_req_q;
  assign bus.arb_addr      = addr_q;
  assign bus.arb_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_req_port.sv
// Self-checking bench for mem_req_port: directed cases plus randomized transactions against a transaction-level model.
module tb_mem_req_port;
  import mem_port_pkg::*;

  localparam int unsigned G   = 2;
  localparam int unsigned TMO = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_req_port_if bus ();

  mem_req_port #(
    .ADDR_W         (MEM_ADDR_W),
    .DATA_W         (MEM_DATA_W),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int last_fall = -1;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: reads return the arbiter data, writes return zero.
  function automatic logic [15:0] model_rdata(input logic we, input logic [15:0] arb_data);
    return we ? 16'h0000 : arb_data;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (bus.cpu_req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 32'(bus.cpu_req_ready), 32'd1);
  endtask

  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] arb_data, input int lat, input int stall, input bit junk);
    logic [15:0] exp;
    wait_ready();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = we;
    bus.cpu_addr      = addr;
    bus.cpu_wdata     = wdata;
    exp_q.push_back(model_rdata(we, arb_data));
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    check("rd_req_rise", 32'(bus.arb_rd_req), 32'(!we));
    check("wr_req_rise", 32'(bus.arb_wr_req), 32'(we));
    check("arb_addr", 32'(bus.arb_addr), 32'(addr));
    check("arb_wdata", 32'(bus.arb_wdata), 32'(wdata));
    check("req_ready_busy", 32'(bus.cpu_req_ready), 32'd0);
    if (last_fall >= 0) check("gap_low_cycles", 32'((cyc - last_fall) >= int'(G)), 32'd1);
    for (int i = 0; i < lat; i++) begin
      if (junk) begin
        bus.cpu_req_valid = 1'($urandom_range(0, 1));
        bus.cpu_addr      = 16'($urandom);
        bus.cpu_we        = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("req_hold", {30'd0, bus.arb_wr_req, bus.arb_rd_req}, {30'd0, we, !we});
      check("addr_hold", 32'(bus.arb_addr), 32'(addr));
      check("wdata_hold", 32'(bus.arb_wdata), 32'(wdata));
      check("no_early_rsp", 32'(bus.cpu_rsp_valid), 32'd0);
    end
    bus.cpu_req_valid = 1'b0;
    bus.arb_done      = 1'b1;
    bus.arb_rdata     = arb_data;
    @(negedge clk);
    bus.arb_done  = 1'b0;
    bus.arb_rdata = 16'($urandom);
    check("req_drop", {30'd0, bus.arb_wr_req, bus.arb_rd_req}, 32'd0);
    last_fall = cyc;
    for (int k = 1; k <= int'(G); k++) begin
      if (k > 1) @(negedge clk);
      check("gap_no_rsp", 32'(bus.cpu_rsp_valid), 32'd0);
      check("gap_req_low", {30'd0, bus.arb_wr_req, bus.arb_rd_req}, 32'd0);
      bus.arb_done = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.arb_done = 1'b0;
    exp = exp_q.pop_front();
    check("rsp_valid_lat", 32'(bus.cpu_rsp_valid), 32'd1);
    check("rsp_rdata", 32'(bus.cpu_rdata), 32'(exp));
    check("rsp_err", 32'(bus.cpu_rsp_err), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.cpu_rsp_valid), 32'd1);
      check("stall_rdata", 32'(bus.cpu_rdata), 32'(exp));
      check("stall_ready", 32'(bus.cpu_req_ready), 32'd0);
    end
    bus.cpu_rsp_ready = 1'b1;
    @(negedge clk);
    bus.cpu_rsp_ready = 1'b0;
    check("rsp_clear", {30'd0, bus.cpu_rsp_err, bus.cpu_rsp_valid}, 32'd0);
    check("back_to_idle", 32'(bus.cpu_req_ready), 32'd1);
  endtask

  initial begin
    bus.cpu_req_valid = 1'b0;
    bus.cpu_we        = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    bus.cpu_rsp_ready = 1'b0;
    bus.arb_done      = 1'b0;
    bus.arb_rdata     = '0;

    #2;
    check("reset_outputs", {bus.cpu_req_ready, bus.cpu_rsp_valid, bus.cpu_rsp_err,
                            bus.arb_rd_req, bus.arb_wr_req}, 32'd0);
    check("reset_data", {bus.cpu_rdata, bus.arb_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.cpu_req_ready), 32'd1);

    // Basic read and write.
    run_txn(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 2, 0, 1'b0);
    run_txn(1'b1, 16'h0100, 16'h1234, 16'hDEAD, 3, 0, 1'b0);
    // Back-to-back reads.
    run_txn(1'b0, 16'h0001, 16'h0000, 16'h1111, 0, 0, 1'b0);
    run_txn(1'b0, 16'h0002, 16'h0000, 16'h2222, 0, 0, 1'b0);
    // Long response stall.
    run_txn(1'b0, 16'h0300, 16'h0000, 16'hA5A5, 1, 10, 1'b0);

    // Reset while waiting on the arbiter.
    wait_ready();
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = 1'b0;
    bus.cpu_addr      = 16'h0777;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    check("pre_reset_rd", 32'(bus.arb_rd_req), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_drops_req", {30'd0, bus.arb_wr_req, bus.arb_rd_req}, 32'd0);
    check("reset_ready_low", 32'(bus.cpu_req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_rsp_after_reset", 32'(bus.cpu_rsp_valid), 32'd0);
      check("ready_after_release", 32'(bus.cpu_req_ready), 32'd1);
    end
    last_fall = -1;

`ifdef MEM_REQ_PORT_TIMEOUT_EN
    begin
      int n = 0;
      wait_ready();
      bus.cpu_req_valid = 1'b1;
      bus.cpu_we        = 1'b1;
      bus.cpu_addr      = 16'h0BAD;
      bus.cpu_wdata     = 16'h5555;
      @(negedge clk);
      bus.cpu_req_valid = 1'b0;
      while (bus.arb_wr_req === 1'b1 && n < 40) begin
        n++;
        @(negedge clk);
      end
      check("timeout_cycles", 32'(n), 32'(TMO));
      for (int k = 1; k <= int'(G); k++) begin
        if (k > 1) @(negedge clk);
        check("tmo_gap_no_rsp", 32'(bus.cpu_rsp_valid), 32'd0);
        bus.arb_done = 1'b1;
      end
      @(negedge clk);
      bus.arb_done = 1'b0;
      check("tmo_rsp_valid", 32'(bus.cpu_rsp_valid), 32'd1);
      check("tmo_rsp_err", 32'(bus.cpu_rsp_err), 32'd1);
      check("tmo_rdata", 32'(bus.cpu_rdata), 32'd0);
      bus.cpu_rsp_ready = 1'b1;
      @(negedge clk);
      bus.cpu_rsp_ready = 1'b0;
      check("tmo_err_clear", {30'd0, bus.cpu_rsp_err, bus.cpu_rsp_valid}, 32'd0);
      last_fall = -1;
    end
    // Completion in the expiry cycle wins over the timeout.
    run_txn(1'b0, 16'h0C0C, 16'h0000, 16'h7E7E, int'(TMO) - 1, 0, 1'b0);
`endif

    for (int t = 0; t < 24; t++) begin
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
